fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller (request / wait / issue FSM)
//
// Purpose: fetches one 12-bit instruction word per cycle of the fetch loop
// from program memory, freezes the PC datapath while a fetch is in flight and
// hands the word to the decoder with a one-cycle inst_valid pulse.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : a fetch waiting TIMEOUT cycles in WAIT is abandoned, NOP_WORD
//               is issued instead, fetch_err pulses and err_cnt counts it.
//   undefined : WAIT waits forever for mem_ack; fetch_err=0, err_cnt=8'h00.
//
// Ports:
//   clk4        in   1   system clock, rising edge
//   resetn      in   1   asynchronous active-low reset
//   pc          in  11   program counter, latched into mem_addr on REQ entry
//   mem_req     out  1   program-memory read request
//   mem_addr    out 11   program-memory read address
//   mem_ack     in   1   program-memory data valid
//   mem_data    in  12   program-memory read data
//   inst        out 12   registered instruction word
//   inst_valid  out  1   one-cycle pulse, inst is new
//   pc_hold     out  1   freezes PC / stack while 1
//   fetch_err   out  1   one-cycle pulse on an abandoned fetch
//   err_cnt     out  8   saturating count of abandoned fetches

module fetch_ctrl #(
    parameter int          TIMEOUT  = 15,
    parameter logic [11:0] NOP_WORD = 12'h000
) (
    input  logic        clk4,
    input  logic        resetn,
    input  logic [10:0] pc,
    output logic        mem_req,
    output logic [10:0] mem_addr,
    input  logic        mem_ack,
    input  logic [11:0] mem_data,
    output logic [11:0] inst,
    output logic        inst_valid,
    output logic        pc_hold,
    output logic        fetch_err,
    output logic [7:0]  err_cnt
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fetch_ctrl: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] addr_q;
    logic [11:0] inst_q;
    logic        take_ack;   // data accepted this cycle
    logic        abandon;    // fetch abandoned this cycle
    logic        timer_done; // WAIT has spent its last allowed cycle

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk4 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; mem_ack is only looked at in REQ and WAIT, so an
    // ack in IDLE or ISSUE has no effect.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        take_ack = 1'b0;
        abandon  = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (mem_ack) begin
                    take_ack = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A late ack in the final timer cycle still wins.
                if (mem_ack) begin
                    take_ack = 1'b1;
                    state_d  = S_ISSUE;
                end else if (timer_done) begin
                    abandon  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        pc_hold    = 1'b1;
        inst_valid = 1'b0;
        case (state_q)
            S_REQ, S_WAIT: mem_req = 1'b1;
            S_ISSUE: begin
                pc_hold    = 1'b0;
                inst_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address and instruction registers. The address is sampled on the
    // edge that enters REQ (from IDLE or ISSUE) and then held until the
    // next fetch, so it is stable across REQ and WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk4 or negedge resetn) begin
        if (!resetn) begin
            addr_q <= 11'h000;
            inst_q <= NOP_WORD;
        end else begin
            if (state_q == S_IDLE || state_q == S_ISSUE) begin
                addr_q <= pc;
            end
            if (take_ack) begin
                inst_q <= mem_data;
            end else if (abandon) begin
                inst_q <= NOP_WORD;
            end
        end
    end

    assign mem_addr = addr_q;
    assign inst     = inst_q;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [7:0] timer_q;
    logic       err_q;
    logic [7:0] cnt_q;

    assign timer_done = (timer_q == TIMER_LAST);

    always_ff @(posedge clk4 or negedge resetn) begin
        if (!resetn) begin
            timer_q <= 8'h00;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            if (state_q == S_REQ) begin
                timer_q <= 8'h00;
            end else if (state_q == S_WAIT && !mem_ack) begin
                timer_q <= timer_q + 8'h01;
            end
            // err_q lines up with the ISSUE cycle that carries NOP_WORD.
            err_q <= abandon;
            if (abandon && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'h01;
            end
        end
    end

    assign fetch_err = err_q;
    assign err_cnt   = cnt_q;
`else
    assign timer_done = 1'b0;
    assign fetch_err  = 1'b0;
    assign err_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl

module tb_fetch_ctrl;

    localparam int          TO  = 15;
    localparam logic [11:0] NOP = 12'h000;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk4 = 1'b0;
    logic        resetn;
    logic [10:0] pc;
    logic        mem_req;
    logic [10:0] mem_addr;
    logic        mem_ack;
    logic [11:0] mem_data;
    logic [11:0] inst;
    logic        inst_valid;
    logic        pc_hold;
    logic        fetch_err;
    logic [7:0]  err_cnt;

    fetch_ctrl #(.TIMEOUT(TO), .NOP_WORD(NOP)) dut (
        .clk4       (clk4),
        .resetn     (resetn),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc_hold    (pc_hold),
        .fetch_err  (fetch_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk4 = ~clk4;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the memory interface should look like per fetch.
    logic [11:0] m_inst;
    logic [10:0] m_addr;
    int          m_cnt;
    int          e_cycles;
    logic [11:0] e_inst;
    logic        e_err;
    logic [10:0] e_addr;
    logic [11:0] e_pre;

    // Observations gathered by the driver for one fetch.
    int          o_cycles;
    bit          o_bad;
    bit          o_addr_ok;
    bit          o_hold_ok;
    bit          o_err_early;
    bit          o_seen;
    logic [10:0] o_addr;
    logic [11:0] o_pre;
    logic        o_hold, o_req, o_err;
    logic [11:0] o_inst;
    logic [7:0]  o_cnt;

    // A fetch whose ack comes 'delay' cycles after REQ entry; it is abandoned
    // when the ack would land after the last of TO wait cycles.
    task automatic model_fetch(input logic [11:0] data, input int delay, input logic [10:0] next_pc);
        bit ab;
        ab       = TO_EN && (delay > TO);
        e_cycles = ab ? TO + 1 : delay + 1;
        e_inst   = ab ? NOP : data;
        e_err    = ab;
        e_addr   = m_addr;
        e_pre    = m_inst;
        if (ab && m_cnt < 255) m_cnt = m_cnt + 1;
        m_inst   = e_inst;
        m_addr   = next_pc;
    endtask

    // Called just after the edge that enters REQ; returns just after the
    // edge that leaves ISSUE. pc is scrambled during the fetch and next_pc
    // is presented in ISSUE together with a stray ack that must be ignored.
    task automatic run_fetch(input logic [11:0] data, input int delay, input logic [10:0] next_pc);
        o_seen = 0; o_cycles = 0; o_bad = 0; o_addr_ok = 1; o_hold_ok = 1; o_err_early = 0;
        model_fetch(data, delay, next_pc);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk4);
            if (inst_valid) begin
                o_seen = 1;
                o_hold = pc_hold; o_req = mem_req; o_err = fetch_err;
                o_inst = inst;    o_cnt = err_cnt;
                pc       = next_pc;
                mem_ack  = 1'($urandom_range(0, 1));
                mem_data = 12'($urandom);
                @(posedge clk4);
                break;
            end
            if (c == 0) begin
                o_addr = mem_addr;
                o_pre  = inst;
            end
            o_cycles++;
            if (!(mem_req && pc_hold)) o_bad = 1;
            if (mem_addr !== o_addr)   o_addr_ok = 0;
            if (inst !== o_pre)        o_hold_ok = 0;
            if (fetch_err)             o_err_early = 1;
            pc       = 11'($urandom);
            mem_ack  = (c == delay);
            mem_data = (c == delay) ? data : 12'($urandom);
            @(posedge clk4);
        end
    endtask

    task automatic do_reset(input logic [10:0] p);
        @(negedge clk4);
        resetn = 1'b0; mem_ack = 1'b0; pc = p;
        @(negedge clk4);
        resetn = 1'b1;
        m_inst = NOP; m_cnt = 0; m_addr = p;
        @(posedge clk4);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (mem_req !== 1'b0)   begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        checks++; if (mem_addr !== 11'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
        checks++; if (inst !== NOP)       begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%0b exp=0", inst_valid); end
        checks++; if (pc_hold !== 1'b1)   begin failures++; $display("FAIL reset_pc_hold got=%0b exp=1", pc_hold); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_fetch_err got=%0b exp=0", fetch_err); end
        checks++; if (err_cnt !== 8'h00)  begin failures++; $display("FAIL reset_err_cnt got=%h exp=00", err_cnt); end
    endtask

    task automatic test_first_fetch();
        @(negedge clk4);
        pc = 11'h000; resetn = 1'b1;
        m_inst = NOP; m_cnt = 0; m_addr = 11'h000;
        #1;
        checks++; if (mem_req !== 1'b0 || pc_hold !== 1'b1) begin failures++; $display("FAIL idle_outputs got req=%0b hold=%0b exp req=0 hold=1", mem_req, pc_hold); end
        @(posedge clk4);
        run_fetch(12'hA05, 0, 11'($urandom));
        checks++; if (!o_seen)               begin failures++; $display("FAIL first_issue_seen got=0 exp=1"); end
        checks++; if (o_cycles !== 1)        begin failures++; $display("FAIL first_latency got=%0d exp=1", o_cycles); end
        checks++; if (o_addr !== 11'h000)    begin failures++; $display("FAIL first_addr got=%h exp=000", o_addr); end
        checks++; if (o_inst !== 12'hA05)    begin failures++; $display("FAIL first_inst got=%h exp=a05", o_inst); end
        checks++; if (o_hold !== 1'b0 || o_req !== 1'b0) begin failures++; $display("FAIL first_issue_outputs got hold=%0b req=%0b exp 0 0", o_hold, o_req); end
    endtask

    task automatic test_delayed_ack();
        run_fetch(12'h900, 3, 11'($urandom));
        checks++; if (o_cycles !== e_cycles)  begin failures++; $display("FAIL delayed_cycles got=%0d exp=%0d", o_cycles, e_cycles); end
        checks++; if (!o_addr_ok || o_addr !== e_addr) begin failures++; $display("FAIL delayed_addr got=%h stable=%0b exp=%h", o_addr, o_addr_ok, e_addr); end
        checks++; if (o_bad)                  begin failures++; $display("FAIL delayed_hold got=bad exp=req&hold"); end
        checks++; if (o_inst !== 12'h900)     begin failures++; $display("FAIL delayed_inst got=%h exp=900", o_inst); end
        checks++; if (o_err !== 1'b0 || o_err_early) begin failures++; $display("FAIL delayed_err got=%0b/%0b exp=0", o_err, o_err_early); end
    endtask

    task automatic test_random_fetches();
        for (int i = 0; i < 40; i++) begin
            logic [11:0] d;
            int          dl;
            d  = 12'($urandom);
            dl = int'($urandom_range(0, TO_EN ? 20 : 12));
            run_fetch(d, dl, 11'($urandom));
            checks++;
            if (!o_seen || o_cycles !== e_cycles || o_bad || !o_addr_ok || o_addr !== e_addr ||
                !o_hold_ok || o_pre !== e_pre || o_inst !== e_inst || o_err !== e_err ||
                o_err_early || o_cnt !== 8'(m_cnt) || o_hold !== 1'b0 || o_req !== 1'b0) begin
                failures++;
                $display("FAIL random_fetch[%0d] got cyc=%0d addr=%h pre=%h inst=%h err=%0b cnt=%h exp cyc=%0d addr=%h pre=%h inst=%h err=%0b cnt=%h",
                         i, o_cycles, o_addr, o_pre, o_inst, o_err, o_cnt, e_cycles, e_addr, e_pre, e_inst, e_err, 8'(m_cnt));
            end
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset(11'h155);
        run_fetch(12'hFFF, 1000, 11'h2AA);
        checks++; if (o_cycles !== TO + 1) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", o_cycles, TO + 1); end
        checks++; if (o_err !== 1'b1)      begin failures++; $display("FAIL timeout_err got=%0b exp=1", o_err); end
        checks++; if (o_inst !== NOP)      begin failures++; $display("FAIL timeout_inst got=%h exp=%h", o_inst, NOP); end
        checks++; if (o_cnt !== 8'h01)     begin failures++; $display("FAIL timeout_cnt got=%h exp=01", o_cnt); end
        run_fetch(12'h123, 15, 11'($urandom));
        checks++; if (o_addr !== 11'h2AA || o_inst !== 12'h123 || o_err !== 1'b0) begin failures++; $display("FAIL timeout_next got addr=%h inst=%h err=%0b exp 2aa 123 0", o_addr, o_inst, o_err); end
    endtask

    task automatic test_saturation();
        do_reset(11'h000);
        for (int i = 0; i < 257; i++) begin
            run_fetch(12'($urandom), 1000, 11'($urandom));
            checks++;
            if (o_cnt !== 8'(m_cnt) || o_err !== 1'b1) begin
                failures++;
                $display("FAIL saturation[%0d] got cnt=%h err=%0b exp cnt=%h err=1", i, o_cnt, o_err, 8'(m_cnt));
            end
        end
        checks++; if (o_cnt !== 8'hFF) begin failures++; $display("FAIL saturation_final got=%h exp=ff", o_cnt); end
    endtask
`else
    task automatic test_long_wait();
        run_fetch(12'h5C3, 100, 11'($urandom));
        checks++; if (o_cycles !== 101) begin failures++; $display("FAIL long_wait_cycles got=%0d exp=101", o_cycles); end
        checks++; if (o_inst !== 12'h5C3 || !o_seen) begin failures++; $display("FAIL long_wait_inst got=%h exp=5c3", o_inst); end
        checks++; if (o_err !== 1'b0 || o_err_early || o_cnt !== 8'h00) begin failures++; $display("FAIL long_wait_err got=%0b/%0b cnt=%h exp 0 00", o_err, o_err_early, o_cnt); end
    endtask
`endif

    task automatic test_reset_mid_fetch();
        logic [10:0] p;
        // Currently just past the edge entering REQ: cycle 0 is REQ, 1..5 WAIT.
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk4);
            mem_ack = 1'b0;
        end
        resetn = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || pc_hold !== 1'b1 || inst_valid !== 1'b0) begin failures++; $display("FAIL midreset_outputs got req=%0b hold=%0b valid=%0b exp 0 1 0", mem_req, pc_hold, inst_valid); end
        checks++; if (fetch_err !== 1'b0 || err_cnt !== 8'h00) begin failures++; $display("FAIL midreset_err got err=%0b cnt=%h exp 0 00", fetch_err, err_cnt); end
        checks++; if (inst !== NOP || mem_addr !== 11'h000) begin failures++; $display("FAIL midreset_regs got inst=%h addr=%h exp %h 000", inst, mem_addr, NOP); end
        @(negedge clk4);
        p = 11'($urandom);
        resetn = 1'b1; pc = p; mem_ack = 1'b1; mem_data = 12'hBEE;
        m_inst = NOP; m_cnt = 0; m_addr = p;
        @(posedge clk4);
        run_fetch(12'h3C7, 2, 11'($urandom));
        checks++; if (o_pre !== NOP)    begin failures++; $display("FAIL late_ack_ignored got=%h exp=%h", o_pre, NOP); end
        checks++; if (o_addr !== p || o_inst !== 12'h3C7 || o_cycles !== 3) begin failures++; $display("FAIL post_reset_fetch got addr=%h inst=%h cyc=%0d exp %h 3c7 3", o_addr, o_inst, o_cycles, p); end
    endtask

    initial begin
        resetn = 1'b0; pc = 11'h000; mem_ack = 1'b0; mem_data = 12'h000;
        m_inst = NOP; m_cnt = 0; m_addr = 11'h000;
        test_reset();
        test_first_fetch();
        test_delayed_ack();
        test_random_fetches();
        test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
        test_saturation();
`else
        test_long_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
